// File: rtl/deser_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the serial-to-parallel deserializer.
//   state_t    : FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10)
//   cnt_width  : bit counter width for a given data word width; one count
//                wider than strictly needed so the optional parity slot
//                (count == WIDTH) still fits.
// No ports (package).
// ---------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deserializador_serie_paralelo_contador_bits.sv
// ---------------------------------------------------------------------------
// contador_bits
// Mod-N up-counter used to count received bits within a frame.
// Ports:
//   clk44kHz : sample clock, rising edge
//   reset    : asynchronous, active-high; count -> 0
//   clear    : synchronous clear (wins over enable)
//   enable   : count-enable; at terminal count the counter wraps to 0
//   tc       : terminal-count flag, high while count == N-1
// ---------------------------------------------------------------------------
module contador_bits
    import deser_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = cnt_width(N)
) (
    input  logic clk44kHz,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(N - 1));

    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            // Wrapping at N-1 leaves the counter at 0 for a back-to-back frame.
            if (tc) count <= '0;
            else    count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/deserializador_serie_paralelo.sv
// ---------------------------------------------------------------------------
// deserializador_serie_paralelo
// Serial-to-parallel front end for the 44 kHz sample path. After a start
// strobe it collects WIDTH serial bits, loads the assembled word into
// dato_out and pulses dato_listo for one cycle (enable of the downstream
// holding register).
// Parameters:
//   WIDTH     : data word width (>= 2)
//   MSB_FIRST : 1 = first received bit ends in dato_out[WIDTH-1]
//               0 = first received bit ends in dato_out[0]
// Ports:
//   clk44kHz   : sample clock, rising edge
//   reset      : asynchronous, active-high
//   start      : frame start strobe, sampled only in IDLE or DONE
//   serial_in  : serial data bit, sampled while in SHIFT
//   dato_out   : last completed word (registered, held between frames)
//   dato_listo : one-cycle pulse, dato_out has just been updated
//   busy       : high while in SHIFT
//   par_error  : one-cycle parity-fail pulse
// Build option:
//   DESER_PARITY_EN : adds an even-parity bit after the data bits. A frame
//   with bad parity leaves dato_out untouched and pulses par_error instead
//   of dato_listo. Without the macro par_error is constant 0.
// ---------------------------------------------------------------------------
module deserializador_serie_paralelo
    import deser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk44kHz,
    input  logic             reset,
    input  logic             start,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dato_out,
    output logic             dato_listo,
    output logic             busy,
    output logic             par_error
);

`ifdef DESER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             last_bit;
    logic             take_start;

    // start is only honoured outside SHIFT: no restart mid-frame.
    assign take_start = start && (state_q == IDLE || state_q == DONE);
    assign busy       = (state_q == SHIFT);

    contador_bits #(
        .N  (FRAME_BITS),
        .CW (CNT_W)
    ) u_contador_bits (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .clear    (take_start),
        .enable   (busy),
        .tc       (last_bit)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = last_bit ? DONE : SHIFT;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register contents after capturing the current serial bit.
    always_comb begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], serial_in}
                            : {serial_in, shift_q[WIDTH-1:1]};
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            dato_out   <= '0;
            dato_listo <= 1'b0;
            par_error  <= 1'b0;
        end else begin
            dato_listo <= 1'b0;
            par_error  <= 1'b0;
            if (state_q == SHIFT) begin
`ifdef DESER_PARITY_EN
                if (!last_bit) begin
                    shift_q <= shift_d;
                end else if (^{shift_q, serial_in} == 1'b0) begin
                    // Even parity over data + parity bit: word accepted.
                    dato_out   <= shift_q;
                    dato_listo <= 1'b1;
                end else begin
                    par_error  <= 1'b1;
                end
`else
                shift_q <= shift_d;
                if (last_bit) begin
                    // Final bit goes straight into the output word.
                    dato_out   <= shift_d;
                    dato_listo <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_deserializador_serie_paralelo.sv
// ---------------------------------------------------------------------------
// tb_deserializador_serie_paralelo
// Drives two deserializers (MSB_FIRST=1 and MSB_FIRST=0) from the same
// serial stream. Expected words are computed from the received bit list and
// queued with the cycle in which the pulse must appear; a monitor on the
// falling edge pops and compares whenever a pulse is seen, and otherwise
// checks that dato_out holds its last accepted value.
// Build option: DESER_PARITY_EN (matches the RTL).
// ---------------------------------------------------------------------------
module tb_deserializador_serie_paralelo;

    localparam int W = 4;
`ifdef DESER_PARITY_EN
    localparam int FB  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = W;
    localparam bit PAR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk44kHz = 1'b0;
    always #5 clk44kHz = ~clk44kHz;

    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic serial_in = 1'b0;

    logic [W-1:0] dout_m, dout_l;
    logic         listo_m, listo_l, busy_m, busy_l, perr_m, perr_l;

    deserializador_serie_paralelo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk44kHz   (clk44kHz),
        .reset      (reset),
        .start      (start),
        .serial_in  (serial_in),
        .dato_out   (dout_m),
        .dato_listo (listo_m),
        .busy       (busy_m),
        .par_error  (perr_m)
    );

    deserializador_serie_paralelo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk44kHz   (clk44kHz),
        .reset      (reset),
        .start      (start),
        .serial_in  (serial_in),
        .dato_out   (dout_l),
        .dato_listo (listo_l),
        .busy       (busy_l),
        .par_error  (perr_l)
    );

    int cyc = 0;
    always @(posedge clk44kHz) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic         err;
        logic [W-1:0] word_m;
        logic [W-1:0] word_l;
        logic [31:0]  cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] hold_m = '0;
    logic [W-1:0] hold_l = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: bit i of the frame is the i-th received bit.
    function automatic exp_t model(input logic [FB-1:0] bits, input int c0);
        exp_t e;
        int   ones;
        e    = '0;
        ones = 0;
        for (int i = 0; i < FB; i++) ones += int'(bits[i]);
        for (int i = 0; i < W; i++) begin
            e.word_m = e.word_m + (W'(bits[i]) << (W - 1 - i));
            e.word_l = e.word_l + (W'(bits[i]) << i);
        end
        e.err = PAR && (ones % 2 != 0);
        e.cyc = c0 + FB;
        return e;
    endfunction

    function automatic logic [FB-1:0] framebits(input logic [W-1:0] d, input bit good);
        logic [FB-1:0] f;
        f        = '0;
        f[W-1:0] = d;
`ifdef DESER_PARITY_EN
        f[W] = good ? ^d : ~^d;
`endif
        return f;
    endfunction

    always @(negedge clk44kHz) begin : monitor
        exp_t e;
        if (reset) begin
            hold_m = '0;
            hold_l = '0;
        end else if (listo_m || listo_l || perr_m || perr_l) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {listo_m, listo_l, perr_m, perr_l}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("dato_listo", {listo_m, listo_l}, e.err ? 32'd0 : 32'd3);
                chk("par_error", {perr_m, perr_l}, e.err ? 32'd3 : 32'd0);
                if (!e.err) begin
                    hold_m = e.word_m;
                    hold_l = e.word_l;
                end
                chk("dato_out_msb", dout_m, hold_m);
                chk("dato_out_lsb", dout_l, hold_l);
            end
        end else begin
            chk("hold_msb", dout_m, hold_m);
            chk("hold_lsb", dout_l, hold_l);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge of the DONE cycle.
    task automatic do_frame(input logic [FB-1:0] bits);
        int c0;
        start = 1'b1;
        @(posedge clk44kHz);
        #1;
        c0 = cyc;
        exp_q.push_back(model(bits, c0));
        for (int i = 0; i < FB; i++) begin
            @(negedge clk44kHz);
            serial_in = bits[i];
            start     = 1'($urandom_range(0, 1));   // must be ignored in SHIFT
            chk("busy_shift", {busy_m, busy_l}, 32'd3);
            @(posedge clk44kHz);
        end
        @(negedge clk44kHz);
        chk("busy_done", {busy_m, busy_l}, 32'd0);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk44kHz);
            @(negedge clk44kHz);
            chk("busy_idle", {busy_m, busy_l}, 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] d;
        bit           good;

        repeat (2) @(posedge clk44kHz);
        #1;
        chk("reset_dato_out", {dout_m, dout_l}, 32'd0);
        chk("reset_listo", {listo_m, listo_l}, 32'd0);
        chk("reset_busy", {busy_m, busy_l}, 32'd0);
        chk("reset_par_error", {perr_m, perr_l}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk44kHz);
        idle(1);

        // 1,0,1,1 then back-to-back 0,1,1,0
        do_frame(framebits(4'b1101, 1'b1));
        do_frame(framebits(4'b0110, 1'b1));
        idle(2);

`ifdef DESER_PARITY_EN
        do_frame(framebits(4'b1101, 1'b0));
        idle(1);
`endif

        // Reset two bits into a frame
        start = 1'b1;
        @(posedge clk44kHz);
        @(negedge clk44kHz);
        start     = 1'b0;
        serial_in = 1'b1;
        @(posedge clk44kHz);
        @(negedge clk44kHz);
        serial_in = 1'b0;
        @(posedge clk44kHz);
        #2 reset = 1'b1;
        #1;
        chk("abort_dato_out", {dout_m, dout_l}, 32'd0);
        chk("abort_listo", {listo_m, listo_l}, 32'd0);
        chk("abort_busy", {busy_m, busy_l}, 32'd0);
        @(posedge clk44kHz);
        #2 reset = 1'b0;
        @(negedge clk44kHz);
        idle(1);

        do_frame(framebits(4'b1111, 1'b1));
        idle(1);

        // Random frames, random back-to-back / idle gaps
        repeat (40) begin
            d    = W'($urandom_range(0, (1 << W) - 1));
            good = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
            do_frame(framebits(d, good));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk44kHz);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
